// File: rtl/fpu_norm_pkg.sv
// ============================================================================
// fpu_norm_pkg : shared FSM encoding and shift-count width for the normalizer
// Rev 1.0
// ============================================================================
`default_nettype none

package fpu_norm_pkg;

   localparam int SHIFT_CNT_W = 5;

   typedef logic [SHIFT_CNT_W-1:0] shift_cnt_t;

   localparam shift_cnt_t CNT_ONE = shift_cnt_t'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } norm_state_e;

endpackage

`default_nettype wire

// File: rtl/exp_sub_normalizer_if.sv
// ============================================================================
// exp_sub_normalizer_if : request/result bundle of the post-op normalizer
// Rev 1.0
// ============================================================================
`default_nettype none

interface exp_sub_normalizer_if #(
   parameter int P = 8,
   parameter int W = 24
);
   import fpu_norm_pkg::*;

   logic             start;
   logic [P-1:0]     exp_in;
   logic [W-1:0]     man_in;
   logic             busy;
   logic             done;
   logic [P-1:0]     exp_out;
   logic [W-1:0]     man_out;
   shift_cnt_t       shift_cnt;
   logic             zero;
   logic             underflow;

   modport master (
      output start, exp_in, man_in,
      input  busy, done, exp_out, man_out, shift_cnt, zero, underflow
   );

   modport slave (
      input  start, exp_in, man_in,
      output busy, done, exp_out, man_out, shift_cnt, zero, underflow
   );

endinterface

`default_nettype wire

// File: rtl/exp_sub_normalizer_exp_dec.sv
// ============================================================================
// exp_dec : P-bit combinational exponent decrement with zero detect
// Rev 1.0
// ============================================================================
`default_nettype none

module exp_dec #(
   parameter int P = 8
) (
   input  logic [P-1:0] exp_i,
   output logic [P-1:0] exp_dec_o,
   output logic         is_zero_o
);

   localparam logic [P-1:0] C_ONE = {{(P-1){1'b0}}, 1'b1};

   assign exp_dec_o = exp_i - C_ONE;
   assign is_zero_o = (exp_i == '0);

endmodule

`default_nettype wire

// File: rtl/exp_sub_normalizer.sv
// ============================================================================
// exp_sub_normalizer : one-bit-per-cycle left normalizer with exponent decrement
// Rev 1.0
// ============================================================================
`default_nettype none

module exp_sub_normalizer
   import fpu_norm_pkg::*;
#(
   parameter int P = 8,
   parameter int W = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   exp_sub_normalizer_if.slave   bus
);

   norm_state_e   state_q, state_d;
   logic [P-1:0]  exp_q,   exp_d;
   logic [W-1:0]  man_q,   man_d;
   shift_cnt_t    cnt_q,   cnt_d;
   logic          zero_q,  zero_d;
   logic          unf_q,   unf_d;

   logic [P-1:0]  exp_m1;
   logic          exp_is_zero;

   exp_dec #(.P(P)) u_exp_dec (
      .exp_i     (exp_q),
      .exp_dec_o (exp_m1),
      .is_zero_o (exp_is_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         exp_q   <= '0;
         man_q   <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         man_q   <= man_d;
         cnt_q   <= cnt_d;
         zero_q  <= zero_d;
         unf_q   <= unf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      man_d   = man_q;
      cnt_d   = cnt_q;
      zero_d  = zero_q;
      unf_d   = unf_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               exp_d   = bus.exp_in;
               man_d   = bus.man_in;
               cnt_d   = '0;
               zero_d  = 1'b0;
               unf_d   = 1'b0;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: state_d = ST_SHIFT;
         ST_SHIFT: begin
            // Exponent-zero test sits before the shift so the decrement never wraps.
            if (man_q == '0) begin
               zero_d  = 1'b1;
               exp_d   = '0;
               state_d = ST_DONE;
            end else if (man_q[W-1]) begin
               state_d = ST_DONE;
            end else if (exp_is_zero) begin
               unf_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               man_d = {man_q[W-2:0], 1'b0};
               exp_d = exp_m1;
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.done      = (state_q == ST_DONE);
   assign bus.exp_out   = exp_q;
   assign bus.man_out   = man_q;
   assign bus.shift_cnt = cnt_q;
   assign bus.zero      = zero_q;
   assign bus.underflow = unf_q;

endmodule

`default_nettype wire

// File: tb/tb_exp_sub_normalizer.sv
// ============================================================================
// tb_exp_sub_normalizer : scoreboard bench with a leading-zero reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_exp_sub_normalizer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   exp_sub_normalizer_if #(.P(8), .W(24)) bus ();

   exp_sub_normalizer #(.P(8), .W(24)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [7:0]  ex;
      logic [23:0] mn;
      int          cnt;
      bit          zero;
      bit          unf;
      int          lat;
      int          t0;
   } exp_t;

   exp_t q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Result defined by leading-zero count, limited by how far the exponent can drop.
   function automatic exp_t model(input logic [7:0] e, input logic [23:0] m);
      exp_t r;
      int   lz;
      lz = 0;
      while (lz < 24 && m[23-lz] == 1'b0) lz++;
      r.t0 = 0;
      if (m == 24'h0) begin
         r.ex = 8'h0; r.mn = 24'h0; r.cnt = 0; r.zero = 1; r.unf = 0; r.lat = 2;
      end else if (int'(e) >= lz) begin
         r.ex = 8'(int'(e) - lz); r.mn = m << lz; r.cnt = lz;
         r.zero = 0; r.unf = 0; r.lat = lz + 2;
      end else begin
         r.ex = 8'h0; r.mn = m << e; r.cnt = int'(e);
         r.zero = 0; r.unf = 1; r.lat = int'(e) + 2;
      end
      return r;
   endfunction

   // Called at a falling edge; waits for idle, then launches one request.
   task automatic issue(input logic [7:0] e, input logic [23:0] m);
      int   n;
      exp_t r;
      n = 0;
      while (bus.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("idle_timeout", 32'(bus.busy), 32'd0);
      bus.start  = 1'b1;
      bus.exp_in = e;
      bus.man_in = m;
      @(posedge clk);
      #1;
      r    = model(e, m);
      r.t0 = cyc;
      q.push_back(r);
      @(negedge clk);
      bus.start  = 1'b0;
      bus.exp_in = 8'($urandom());
      bus.man_in = 24'($urandom());
   endtask

   initial begin : monitor
      exp_t r;
      forever begin
         @(negedge clk);
         if (!rst && bus.done) begin
            if (q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               r = q.pop_front();
               chk("latency",   32'(cyc - r.t0), 32'(r.lat));
               chk("exp_out",   32'(bus.exp_out), 32'(r.ex));
               chk("man_out",   32'(bus.man_out), 32'(r.mn));
               chk("shift_cnt", 32'(bus.shift_cnt), 32'(r.cnt));
               chk("zero",      32'(bus.zero), 32'(r.zero));
               chk("underflow", 32'(bus.underflow), 32'(r.unf));
            end
         end
      end
   end

   initial begin : stimulus
      logic [7:0]  e;
      logic [23:0] m;
      int          n;
      bus.start  = 1'b0;
      bus.exp_in = 8'h0;
      bus.man_in = 24'h0;
      repeat (3) @(negedge clk);
      chk("rst_busy",      32'(bus.busy), 32'd0);
      chk("rst_done",      32'(bus.done), 32'd0);
      chk("rst_exp_out",   32'(bus.exp_out), 32'd0);
      chk("rst_man_out",   32'(bus.man_out), 32'd0);
      chk("rst_shift_cnt", 32'(bus.shift_cnt), 32'd0);
      chk("rst_zero",      32'(bus.zero), 32'd0);
      chk("rst_underflow", 32'(bus.underflow), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(8'h80, 24'h800000);
      issue(8'h80, 24'h000100);
      issue(8'h45, 24'h000000);
      issue(8'h03, 24'h010000);
      issue(8'h10, 24'h400000);
      issue(8'h00, 24'h000001);
      issue(8'h17, 24'h000001);

      // Long op, a stray start while busy, then reset mid-flight.
      n = 0;
      while (bus.busy && n < 200) begin @(negedge clk); n++; end
      issue(8'h80, 24'h000001);
      repeat (2) @(negedge clk);
      bus.start  = 1'b1;
      bus.exp_in = 8'h22;
      bus.man_in = 24'h0F0000;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      chk("mid_rst_busy",      32'(bus.busy), 32'd0);
      chk("mid_rst_done",      32'(bus.done), 32'd0);
      chk("mid_rst_exp_out",   32'(bus.exp_out), 32'd0);
      chk("mid_rst_man_out",   32'(bus.man_out), 32'd0);
      chk("mid_rst_shift_cnt", 32'(bus.shift_cnt), 32'd0);
      chk("mid_rst_zero",      32'(bus.zero), 32'd0);
      chk("mid_rst_underflow", 32'(bus.underflow), 32'd0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("post_rst_idle", 32'(bus.busy), 32'd0);
      issue(8'h80, 24'h000100);

      for (int i = 0; i < 40; i++) begin
         m = 24'($urandom() >> $urandom_range(0, 31));
         if ($urandom_range(0, 9) == 0) m = 24'h0;
         e = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 25)) : 8'($urandom());
         issue(e, m);
         if ($urandom_range(0, 2) == 0) begin
            bus.start  = 1'b1;
            bus.exp_in = 8'($urandom());
            bus.man_in = 24'($urandom());
            @(negedge clk);
            bus.start = 1'b0;
         end
      end

      n = 0;
      while (q.size() > 0 && n < 500) begin @(negedge clk); n++; end
      if (q.size() > 0) chk("drain_timeout", 32'(q.size()), 32'd0);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
